data_ram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 16-bit data RAM. It sits between two requesters (port 0: CPU load/store stage; port 1: debug/DMA loader) and the single data RAM port. It serialises their accesses, drives the RAM's chip select and read/write lines with registered outputs, and returns read data with a one-cycle valid pulse.

---
 rtl/data_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_ram_arbiter
//  Description : Two-port round-robin arbiter and access sequencer for the
//                16-bit data RAM. Port 0 is the CPU load/store stage and
//                port 1 is the debug/DMA loader. Accesses are serialised onto
//                the single RAM port through registered cs/rnw/addr/wdata.
//                Read data comes back with a one-cycle rvalid pulse.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                m*_req/rnw/addr/wdata - requester inputs (held until gnt)
//                m*_gnt                - one-cycle accept pulse
//                m*_rvalid/rdata       - read return (rdata held until next)
//                busy                  - high whenever the sequencer is busy
//                ram_cs/rnw/addr/wdata - registered RAM control
//                ram_rdata             - RAM read data (valid in RESP cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter #(
  parameter int DATA_BUS_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m0_req,
  input  logic                      m0_rnw,
  input  logic [DATA_BUS_WIDTH-1:0] m0_addr,
  input  logic [DATA_BUS_WIDTH-1:0] m0_wdata,
  input  logic                      m1_req,
  input  logic                      m1_rnw,
  input  logic [DATA_BUS_WIDTH-1:0] m1_addr,
  input  logic [DATA_BUS_WIDTH-1:0] m1_wdata,
  output logic                      m0_gnt,
  output logic                      m1_gnt,
  output logic                      m0_rvalid,
  output logic                      m1_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] m0_rdata,
  output logic [DATA_BUS_WIDTH-1:0] m1_rdata,
  output logic                      busy,
  output logic                      ram_cs,
  output logic                      ram_rnw,
  output logic [DATA_BUS_WIDTH-1:0] ram_addr,
  output logic [DATA_BUS_WIDTH-1:0] ram_wdata,
  input  logic [DATA_BUS_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // port that won the most recent grant
  logic   owner;       // port that owns the access in flight

  // Port 1 wins when it is the only requester, or when both request and
  // port 0 was granted last. Resetting last_grant to 1 hands the first tie
  // to port 0.
  logic pick1;
  assign pick1 = m1_req & (~m0_req | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
      ram_cs     <= 1'b0;
      ram_rnw    <= 1'b1;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      // gnt and rvalid are single-cycle pulses
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner      <= pick1;
            last_grant <= pick1;
            ram_cs     <= 1'b1;
            ram_rnw    <= pick1 ? m1_rnw   : m0_rnw;
            ram_addr   <= pick1 ? m1_addr  : m0_addr;
            ram_wdata  <= pick1 ? m1_wdata : m0_wdata;
            m0_gnt     <= ~pick1;
            m1_gnt     <= pick1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          // The RAM samples cs on this edge; rnw/addr/wdata stay put so the
          // bus never changes while cs is high.
          ram_cs <= 1'b0;
          if (ram_rnw) begin
            state <= RESP;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RESP: begin
          if (owner) begin
            m1_rdata  <= ram_rdata;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= ram_rdata;
            m0_rvalid <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          ram_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_ram_arbiter
//  Description : Self-checking bench for data_ram_arbiter. A behavioural RAM
//                answers the DUT; a reference memory produces expected read
//                data, queued per port at grant time and popped on rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m0_req, m0_rnw, m1_req, m1_rnw;
  logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic         ram_cs, ram_rnw;
  logic [W-1:0] ram_addr, ram_wdata;
  wire  [W-1:0] ram_rdata;

  data_ram_arbiter #(.DATA_BUS_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .busy(busy),
    .ram_cs(ram_cs), .ram_rnw(ram_rnw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural RAM: registered read, Z when deselected ---
  logic [W-1:0] ram_mem [0:4095];
  logic [W-1:0] ram_q     = '0;
  logic         ram_drive = 1'b0;
  always @(posedge clk) begin
    ram_drive <= ram_cs;
    if (ram_cs) begin
      if (ram_rnw) ram_q <= ram_mem[ram_addr[11:0]];
      else         ram_mem[ram_addr[11:0]] <= ram_wdata;
    end
  end
  assign ram_rdata = ram_drive ? ram_q : 'z;

  // ---------------- reference model and scoreboard ----------------------
  logic [W-1:0] ref_mem [0:4095];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           gnt_port_log[$];
  int           gnt_cyc_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  int   last_gnt0 = 0, last_gnt1 = 0, last_rv0 = 0, last_rv1 = 0, cs_cnt = 0;
  logic prev_cs = 1'b0, prev_g0 = 1'b0, prev_g1 = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0;

  always @(negedge clk) begin
    if (m0_gnt) begin gnt_port_log.push_back(0); gnt_cyc_log.push_back(cyc); last_gnt0 <= cyc; end
    if (m1_gnt) begin gnt_port_log.push_back(1); gnt_cyc_log.push_back(cyc); last_gnt1 <= cyc; end
    if (m0_rvalid) begin
      if (exp_q0.size() == 0) check("rv0_unexpected", 1, 0);
      else begin
        check("rdata0", m0_rdata, exp_q0.pop_front());
        check("rv0_latency", cyc - last_gnt0, 2);
      end
      last_rv0 <= cyc;
    end
    if (m1_rvalid) begin
      if (exp_q1.size() == 0) check("rv1_unexpected", 1, 0);
      else begin
        check("rdata1", m1_rdata, exp_q1.pop_front());
        check("rv1_latency", cyc - last_gnt1, 2);
      end
      last_rv1 <= cyc;
    end
    if (prev_cs) check("cs_one_cycle", ram_cs, 0);
    if (prev_g0) check("gnt0_pulse", m0_gnt, 0);
    if (prev_g1) check("gnt1_pulse", m1_gnt, 0);
    if (prev_r0) check("rv0_pulse", m0_rvalid, 0);
    if (prev_r1) check("rv1_pulse", m1_rvalid, 0);
    if (ram_cs) cs_cnt <= cs_cnt + 1;
    prev_cs <= ram_cs;
    prev_g0 <= m0_gnt;
    prev_g1 <= m1_gnt;
    prev_r0 <= m0_rvalid;
    prev_r1 <= m1_rvalid;
  end

  // ---------------- driver ----------------
  // Called at a negedge. Presents a request, waits for its grant, then
  // updates the reference model / scoreboard. hold keeps req high so the
  // caller can chain the next transaction on the same port.
  task automatic drive(input int p, input logic rnw, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata, input bit hold, output int waited);
    bit got = 1'b0;
    waited = 0;
    if (p == 0) begin m0_req = 1'b1; m0_rnw = rnw; m0_addr = addr; m0_wdata = wdata; end
    else        begin m1_req = 1'b1; m1_rnw = rnw; m1_addr = addr; m1_wdata = wdata; end
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      if ((p == 0 && m0_gnt) || (p == 1 && m1_gnt)) got = 1'b1;
    end
    if (got) begin
      if (rnw) begin
        if (p == 0) exp_q0.push_back(ref_mem[addr[11:0]]);
        else        exp_q1.push_back(ref_mem[addr[11:0]]);
      end else begin
        ref_mem[addr[11:0]] = wdata;
      end
    end else begin
      check("gnt_timeout", 0, 1);
    end
    if (!hold) begin
      if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic check_rst_vals();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_rnw", ram_rnw, 1);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, w1, c0, base_log, base_cs;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = W'(i);
      ref_mem[i] = W'(i);
    end
    rst_n = 1'b0;
    m0_req = 1'b0; m0_rnw = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_rnw = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(negedge clk);
    check_rst_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of addr 4 by m0
    base_log = gnt_port_log.size();
    base_cs  = cs_cnt;
    drive(0, 1'b1, 16'd4, 16'h0, 1'b0, w0);
    check("single_gnt_wait", w0, 1);
    drain();
    check("single_m0_rdata", m0_rdata, 16'h0004);
    check("single_cs_cycles", cs_cnt - base_cs, 1);
    check("single_gnt_count", gnt_port_log.size() - base_log, 1);
    check("single_m1_rdata", m1_rdata, 0);

    // m1 writes BEEF to addr 40 then reads it back
    c0 = cyc;
    drive(1, 1'b0, 16'd40, 16'hBEEF, 1'b1, w1);
    drive(1, 1'b1, 16'd40, 16'h0, 1'b0, w1);
    drain();
    check("wr_rd_total_cycles", last_rv1 - c0, 5);
    check("wr_rd_m1_rdata", m1_rdata, 16'hBEEF);

    // Tie: both ports hold read requests continuously
    base_log = gnt_port_log.size();
    fork
      begin
        drive(0, 1'b1, 16'd1, 16'h0, 1'b1, w0);
        drive(0, 1'b1, 16'd1, 16'h0, 1'b1, w0);
        drive(0, 1'b1, 16'd1, 16'h0, 1'b0, w0);
      end
      begin
        drive(1, 1'b1, 16'd2, 16'h0, 1'b1, w1);
        drive(1, 1'b1, 16'd2, 16'h0, 1'b1, w1);
        drive(1, 1'b1, 16'd2, 16'h0, 1'b0, w1);
      end
    join
    drain();
    check("tie_gnt_count", gnt_port_log.size() - base_log, 6);
    for (int i = 0; i < 6 && base_log + i < gnt_port_log.size(); i++) begin
      check("tie_order", gnt_port_log[base_log + i], i % 2);
      if (i > 0) check("tie_spacing",
                       gnt_cyc_log[base_log + i] - gnt_cyc_log[base_log + i - 1], 3);
    end

    // Held request: m1 arrives while m0's read is in flight
    fork
      drive(0, 1'b1, 16'd7, 16'h0, 1'b0, w0);
      begin
        @(negedge clk);
        drive(1, 1'b1, 16'd9, 16'h0, 1'b0, w1);
      end
    join
    drain();
    check("held_gnt_after_rv", last_gnt1 - last_rv0, 1);
    check("held_m1_rdata", m1_rdata, 16'd9);

    // Reset during ACCESS of a read
    drive(0, 1'b1, 16'd5, 16'h0, 1'b0, w0);
    rst_n = 1'b0;
    exp_q0.delete();
    #1;
    check_rst_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_rvalid_rdata", m0_rdata, 0);
    drive(0, 1'b1, 16'd8, 16'h0, 1'b0, w0);
    check("post_rst_gnt_wait", w0, 1);
    drain();
    check("post_rst_m0_rdata", m0_rdata, 16'd8);

    // Write isolation: m0 writes 1234 to addr 16
    base_cs = cs_cnt;
    drive(0, 1'b0, 16'd16, 16'h1234, 1'b0, w0);
    check("wiso_cs", ram_cs, 1);
    check("wiso_rnw", ram_rnw, 0);
    check("wiso_addr", ram_addr, 16'd16);
    check("wiso_wdata", ram_wdata, 16'h1234);
    @(negedge clk);
    check("wiso_cs_drop", ram_cs, 0);
    repeat (3) @(negedge clk);
    check("wiso_cs_cycles", cs_cnt - base_cs, 1);
    check("wiso_m0_rdata_held", m0_rdata, 16'd8);
    drive(0, 1'b1, 16'd16, 16'h0, 1'b0, w0);
    drain();
    check("wiso_readback", m0_rdata, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
